// File: rtl/binary_decoder_scan_pkg.sv
// Shared types and helpers for the scanning binary decoder.
package binary_decoder_pkg;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } mode_e;

    // Idle level of a width-bit select bus; callers cast the result down to their width.
    function automatic logic [255:0] inactive_pattern(input logic active_low, input int width);
        logic [255:0] mask;
        mask = (256'(1) << width) - 256'(1);
        return active_low ? mask : 256'(0);
    endfunction

endpackage

// File: rtl/binary_decoder_n.sv
// Combinational N-to-2^N one-hot decoder with enable; output is active-high.
module binary_decoder_n #(
    parameter int IN_BITS  = 4,
    localparam int OUT_BITS = 1 << IN_BITS
) (
    input  logic [IN_BITS-1:0]  in,
    input  logic                en,
    output logic [OUT_BITS-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/binary_decoder_scan.sv
// Registered binary decoder with a built-in scan sequencer that walks every output
// for a programmable dwell; used for row/digit selects on multiplexed displays.
module binary_decoder_scan
    import binary_decoder_pkg::*;
#(
    parameter int   IN_BITS      = 4,
    parameter int   DWELL_CYCLES = 4,
    parameter logic ACTIVE_LOW   = 1'b0,
    localparam int  OUT_BITS     = 1 << IN_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                scan,
    input  logic [IN_BITS-1:0]  in,
    output logic [OUT_BITS-1:0] out,
    output logic [IN_BITS-1:0]  idx,
    output logic                valid,
    output logic                wrap
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IN_BITS-1:0]  IDX_MAX  = {IN_BITS{1'b1}};
    localparam logic [OUT_BITS-1:0] POL_MASK = OUT_BITS'(inactive_pattern(ACTIVE_LOW, OUT_BITS));

    mode_e               mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_BITS-1:0]  idx_q, idx_d;
    logic [OUT_BITS-1:0] out_q;
    logic                valid_q, valid_d;
    logic                wrap_q, wrap_d;
    logic                dec_en;
    logic [OUT_BITS-1:0] dec_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= DIRECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= POL_MASK;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= dec_out ^ POL_MASK;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // The mode register only serves to detect scan entry; the scan input itself
    // decides which behaviour applies on each edge.
    always_comb begin
        mode_d  = scan ? SCAN : DIRECT;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        dec_en  = 1'b0;
        if (!scan) begin
            if (en) begin
                idx_d   = in;
                valid_d = 1'b1;
                dec_en  = 1'b1;
            end
        end else if (mode_q == DIRECT) begin
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = en;
            dec_en  = en;
        end else if (en) begin
            valid_d = 1'b1;
            dec_en  = 1'b1;
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                idx_d  = idx_q + IN_BITS'(1);
                wrap_d = (idx_q == IDX_MAX);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Decoding the next index keeps out and idx in step on the same edge.
    binary_decoder_n #(
        .IN_BITS(IN_BITS)
    ) u_dec (
        .in (idx_d),
        .en (dec_en),
        .out(dec_out)
    );

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_binary_decoder_scan.sv
// Bench for binary_decoder_scan: a default instance and a small active-low,
// single-cycle-dwell instance share one stimulus stream and one scoreboard.
module tb_binary_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       scan = 1'b0;
    logic [3:0] in_v = 4'd0;

    logic [15:0] out_a;
    logic [3:0]  idx_a;
    logic        valid_a, wrap_a;
    logic [7:0]  out_b;
    logic [2:0]  idx_b;
    logic        valid_b, wrap_b;

    binary_decoder_scan dut_a (
        .clk(clk), .rst(rst), .en(en), .scan(scan), .in(in_v),
        .out(out_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
    );

    binary_decoder_scan #(
        .IN_BITS(3), .DWELL_CYCLES(1), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .scan(scan), .in(in_v[2:0]),
        .out(out_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected record: {out[15:0], idx[3:0], valid, wrap}
    logic [21:0] exp_a[$];
    logic [21:0] exp_b[$];

    // Reference model: scan position is "enabled cycles since entry".
    int m_p[2];
    bit m_prev[2];
    int m_idx[2];
    bit m_valid[2];
    bit m_wrap[2];

    function automatic logic [21:0] model_step(int k, bit r, bit e, bit s, int i);
        int n;
        int d;
        bit al;
        int o;
        n  = (k == 0) ? 16 : 8;
        d  = (k == 0) ? 4 : 1;
        al = (k == 1);
        if (r) begin
            m_p[k] = 0; m_prev[k] = 0; m_idx[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
        end else if (!s) begin
            m_prev[k] = 0;
            m_wrap[k] = 0;
            m_valid[k] = e;
            if (e) m_idx[k] = i % n;
        end else if (!m_prev[k]) begin
            m_prev[k] = 1;
            m_p[k] = 0;
            m_idx[k] = 0;
            m_valid[k] = e;
            m_wrap[k] = 0;
        end else begin
            m_valid[k] = e;
            m_wrap[k] = 0;
            if (e) begin
                m_p[k] = m_p[k] + 1;
                m_idx[k] = (m_p[k] / d) % n;
                m_wrap[k] = (m_p[k] % (n * d)) == 0;
            end
        end
        o = m_valid[k] ? (1 << m_idx[k]) : 0;
        if (al) o = o ^ ((1 << n) - 1);
        return {16'(o), 4'(m_idx[k]), m_valid[k], m_wrap[k]};
    endfunction

    task automatic step(bit r, bit e, bit s, logic [3:0] i);
        rst = r; en = e; scan = s; in_v = i;
        @(posedge clk);
        exp_a.push_back(model_step(0, r, e, s, int'(i)));
        exp_b.push_back(model_step(1, r, e, s, int'(i)));
        #1;
    endtask

    // Monitor: every cycle both instances present a registered result.
    always @(negedge clk) begin
        logic [21:0] e;
        logic [21:0] g;
        cyc = cyc + 1;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            g = {out_a, idx_a, valid_a, wrap_a};
            total = total + 1;
            if (g !== e) begin
                bad = bad + 1;
                $display("FAIL a_cycle %0d: got out=%h idx=%0d valid=%b wrap=%b, want out=%h idx=%0d valid=%b wrap=%b",
                         cyc, g[21:6], g[5:2], g[1], g[0], e[21:6], e[5:2], e[1], e[0]);
            end
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            g = {8'h00, out_b, 1'b0, idx_b, valid_b, wrap_b};
            total = total + 1;
            if (g !== e) begin
                bad = bad + 1;
                $display("FAIL b_cycle %0d: got out=%h idx=%0d valid=%b wrap=%b, want out=%h idx=%0d valid=%b wrap=%b",
                         cyc, g[21:6], g[5:2], g[1], g[0], e[21:6], e[5:2], e[1], e[0]);
            end
        end
    end

    initial begin
        bit cur_scan;
        // Reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Direct sweep, then disabled
        for (int i = 0; i < 16; i++) step(0, 1, 0, 4'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'($urandom_range(0, 15)));
        // Full scan sweep with wrap at cycle 64; in is ignored
        for (int i = 0; i < 70; i++) step(0, 1, 1, 4'($urandom_range(0, 15)));
        step(1, 0, 0, 0);
        step(0, 1, 0, 4'd3);
        // Pause mid-dwell on idx 5 then resume
        for (int i = 0; i < 22; i++) step(0, 1, 1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) step(0, 1, 1, 4'($urandom_range(0, 15)));
        // Reset mid-scan at idx 9
        step(0, 1, 0, 4'd0);
        for (int i = 0; i < 37; i++) step(0, 1, 1, 4'd0);
        step(1, 1, 1, 4'd5);
        step(0, 0, 0, 4'd0);
        // Mode switch at idx 7, then restart scanning
        for (int i = 0; i < 29; i++) step(0, 1, 1, 4'd0);
        step(0, 1, 0, 4'd2);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 4'd0);
        // Random traffic
        cur_scan = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) cur_scan = ~cur_scan;
            step(bit'($urandom_range(0, 99) == 0), bit'($urandom_range(0, 9) != 0),
                 cur_scan, 4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        #1;
        total = total + 1;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", exp_a.size(), exp_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
